// File: rtl/coord_scan_ctrl.sv
// coord_scan_ctrl
// Walks a rectangular grid of block positions in raster order (X fastest).
// For each position it loads the upper-left X/Y coordinate into the
// interpolation coordinate registers, launches one datapath pass, waits for
// that pass to finish and then advances. DONE pulses after the last pass.
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous reset, active-high
//   START     scan request (only looked at in IDLE)
//   ABORT     cancel a scan in progress (ignored in IDLE)
//   DP_DONE   datapath finished the current pass (only looked at in WAIT)
//   WE_X/WE_Y write enables for the X/Y coordinate registers
//   COORD_X/Y signed 8-bit coordinate of the current position
//   DP_START  one-cycle launch pulse to the datapath
//   BUSY      high in every state except IDLE
//   DONE      one-cycle pulse after the final pass completes
//   BLK_IDX   0-based raster index of the current position
module coord_scan_ctrl #(
  parameter logic signed [7:0] X_MIN = -8'sd8,
  parameter logic signed [7:0] X_MAX = 8'sd7,
  parameter logic signed [7:0] Y_MIN = -8'sd8,
  parameter logic signed [7:0] Y_MAX = 8'sd7,
  parameter int unsigned       STEP  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              DP_DONE,
  output logic              WE_X,
  output logic              WE_Y,
  output logic signed [7:0] COORD_X,
  output logic signed [7:0] COORD_Y,
  output logic              DP_START,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        BLK_IDX
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  // Limits widened to 9 bits so X+STEP / Y+STEP never wrap before compare.
  localparam logic signed [8:0] STEP9 = 9'(STEP);
  localparam logic signed [8:0] XMAX9 = {X_MAX[7], X_MAX};
  localparam logic signed [8:0] YMAX9 = {Y_MAX[7], Y_MAX};

  state_t            state_q, state_d;
  logic signed [7:0] x_q, x_d;
  logic signed [7:0] y_q, y_d;
  logic [7:0]        idx_q, idx_d;
  // Set for the first position and after every row wrap: Y must be rewritten.
  logic              wy_q, wy_d;

  logic signed [8:0] nx, ny;
  logic              x_wrap, y_wrap, last_pos;

  assign nx       = {x_q[7], x_q} + STEP9;
  assign ny       = {y_q[7], y_q} + STEP9;
  assign x_wrap   = nx > XMAX9;
  assign y_wrap   = ny > YMAX9;
  assign last_pos = x_wrap && y_wrap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      wy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      wy_q    <= wy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    wy_d    = wy_q;
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_LOAD;
            x_d     = X_MIN;
            y_d     = Y_MIN;
            idx_d   = '0;
            wy_d    = 1'b1;
          end
        end
        S_LOAD: begin
          state_d = S_LAUNCH;
          wy_d    = 1'b0;
        end
        S_LAUNCH: state_d = S_WAIT;
        S_WAIT: begin
          if (DP_DONE) begin
            if (last_pos) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_LOAD;
              idx_d   = idx_q + 8'd1;
              if (!x_wrap) begin
                x_d = nx[7:0];
              end else begin
                // Not the last position, so ny is known to be within Y_MAX.
                x_d  = X_MIN;
                y_d  = ny[7:0];
                wy_d = 1'b1;
              end
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Control outputs decode the state register only: no input-to-output path.
  assign WE_X     = (state_q == S_LOAD);
  assign WE_Y     = (state_q == S_LOAD) && wy_q;
  assign DP_START = (state_q == S_LAUNCH);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FINISH);
  assign COORD_X  = x_q;
  assign COORD_Y  = y_q;
  assign BLK_IDX  = idx_q;

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// Scoreboard bench for coord_scan_ctrl. Three instances: default grid,
// a grid at the top of the signed 8-bit range, and a single-position grid.
// The reference model enumerates grid positions with plain nested loops.
module tb_coord_scan_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ABORT = 1'b0;
  logic START [3];
  logic DP_DONE [3];
  logic WE_X [3], WE_Y [3], DP_START [3], BUSY [3], DONE [3];
  logic signed [7:0] CX [3], CY [3];
  logic [7:0] BLK [3];

  always #5 CLK = ~CLK;

  coord_scan_ctrl u0 (
    .CLK(CLK), .RST(RST), .START(START[0]), .ABORT(ABORT), .DP_DONE(DP_DONE[0]),
    .WE_X(WE_X[0]), .WE_Y(WE_Y[0]), .COORD_X(CX[0]), .COORD_Y(CY[0]),
    .DP_START(DP_START[0]), .BUSY(BUSY[0]), .DONE(DONE[0]), .BLK_IDX(BLK[0]));

  coord_scan_ctrl #(.X_MIN(8'sd120), .X_MAX(8'sd127), .Y_MIN(8'sh80), .Y_MAX(8'sh80), .STEP(4)) u1 (
    .CLK(CLK), .RST(RST), .START(START[1]), .ABORT(ABORT), .DP_DONE(DP_DONE[1]),
    .WE_X(WE_X[1]), .WE_Y(WE_Y[1]), .COORD_X(CX[1]), .COORD_Y(CY[1]),
    .DP_START(DP_START[1]), .BUSY(BUSY[1]), .DONE(DONE[1]), .BLK_IDX(BLK[1]));

  coord_scan_ctrl #(.X_MIN(8'sd0), .X_MAX(8'sd10), .Y_MIN(8'sd0), .Y_MAX(8'sd10), .STEP(64)) u2 (
    .CLK(CLK), .RST(RST), .START(START[2]), .ABORT(ABORT), .DP_DONE(DP_DONE[2]),
    .WE_X(WE_X[2]), .WE_Y(WE_Y[2]), .COORD_X(CX[2]), .COORD_Y(CY[2]),
    .DP_START(DP_START[2]), .BUSY(BUSY[2]), .DONE(DONE[2]), .BLK_IDX(BLK[2]));

  typedef struct {
    int inst;
    bit is_done;
    int x;
    int y;
    int idx;
    bit wey;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: every grid point in raster order; Y is (re)written on
  // the first column of each row. limit<0 means the scan runs to DONE.
  task automatic push_scan(int inst, int xmin, int xmax, int ymin, int ymax, int step, int limit);
    exp_t e;
    int n;
    n = 0;
    for (int y = ymin; y <= ymax; y += step)
      for (int x = xmin; x <= xmax; x += step) begin
        if (limit < 0 || n < limit) begin
          e.inst = inst; e.is_done = 1'b0; e.x = x; e.y = y; e.idx = n; e.wey = (x == xmin);
          q.push_back(e);
        end
        n++;
      end
    if (limit < 0) begin
      e.inst = inst; e.is_done = 1'b1; e.x = 0; e.y = 0; e.idx = n; e.wey = 1'b0;
      q.push_back(e);
    end
  endtask

  // Datapath responder: DP_DONE some cycles after each DP_START, plus
  // optional stray DP_DONE pulses during LOAD/LAUNCH that must be ignored.
  int cnt [3] = '{0, 0, 0};
  int real_cnt [3] = '{0, 0, 0};
  int max_lat = 1;
  bit stray_en = 1'b0;
  int hold_blk = -1;

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      logic d;
      d = 1'b0;
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          d = 1'b1;
          real_cnt[k]++;
        end
      end
      if (DP_START[k] === 1'b1 && int'(BLK[k]) != hold_blk)
        cnt[k] = $urandom_range(max_lat, 1);
      if (stray_en && (WE_X[k] === 1'b1 || DP_START[k] === 1'b1) && $urandom_range(1, 0) == 1)
        d = 1'b1;
      DP_DONE[k] = d;
    end
  end

  // Monitor: pops the scoreboard whenever a load or DONE is presented.
  int ds_cnt [3] = '{0, 0, 0};
  int base [3] = '{0, 0, 0};
  int wey_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  bit prev_wex [3] = '{0, 0, 0};

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (!RST) begin
      for (int k = 0; k < 3; k++) begin
        if (WE_X[k]) begin
          if (q.size() == 0) chk($sformatf("unexpected_load_u%0d", k), 1, 0);
          else begin
            e = q.pop_front();
            chk("load_inst", k, e.inst);
            chk("load_not_done", 0, int'(e.is_done));
            chk("coord_x", int'(CX[k]), e.x);
            chk("coord_y", int'(CY[k]), e.y);
            chk("blk_idx", int'(BLK[k]), e.idx);
            chk("we_y", int'(WE_Y[k]), int'(e.wey));
            if (e.idx == 0) base[k] = ds_cnt[k] - real_cnt[k];
            else chk("advance_after_dp_done", ds_cnt[k] - real_cnt[k], base[k]);
          end
          if (WE_Y[k]) wey_cnt[k]++;
        end
        if (DP_START[k]) begin
          chk("launch_after_load", int'(prev_wex[k]), 1);
          ds_cnt[k]++;
        end
        if (DONE[k]) begin
          if (q.size() == 0) chk($sformatf("unexpected_done_u%0d", k), 1, 0);
          else begin
            e = q.pop_front();
            chk("done_inst", k, e.inst);
            chk("done_expected", 1, int'(e.is_done));
          end
          chk("done_after_last_dp_done", int'(DP_DONE[k]), 1);
          done_cnt[k]++;
        end
        prev_wex[k] = WE_X[k];
      end
    end
  end

  task automatic start_scan(int k, bit with_abort);
    @(negedge CLK);
    START[k] = 1'b1;
    ABORT = with_abort;
    @(negedge CLK);
    START[k] = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic wait_done(int k, int d0, string nm);
    int c;
    c = 0;
    while (done_cnt[k] == d0 && c < 5000) begin
      @(posedge CLK);
      c++;
    end
    #2;
    chk(nm, done_cnt[k] - d0, 1);
  endtask

  function automatic int outs(int k);
    return int'({WE_X[k], WE_Y[k], DP_START[k], BUSY[k], DONE[k], CX[k], CY[k], BLK[k]});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds0, w0, d0, found;
    for (int k = 0; k < 3; k++) START[k] = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_u%0d", k), outs(k), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Full default scan, DP_DONE one cycle after each launch.
    push_scan(0, -8, 7, -8, 7, 4, -1);
    ds0 = ds_cnt[0]; w0 = wey_cnt[0]; d0 = done_cnt[0];
    start_scan(0, 1'b0);
    wait_done(0, d0, "full_scan_done");
    chk("full_scan_dp_starts", ds_cnt[0] - ds0, 16);
    chk("full_scan_we_y_count", wey_cnt[0] - w0, 4);
    chk("full_scan_queue_empty", q.size(), 0);

    // Random latency, stray DP_DONE pulses, START pulses while busy.
    max_lat = 10; stray_en = 1'b1;
    push_scan(0, -8, 7, -8, 7, 4, -1);
    ds0 = ds_cnt[0]; d0 = done_cnt[0];
    start_scan(0, 1'b0);
    repeat (3) begin
      repeat ($urandom_range(6, 2)) @(negedge CLK);
      START[0] = 1'b1;
      @(negedge CLK);
      START[0] = 1'b0;
    end
    wait_done(0, d0, "rand_lat_done");
    chk("rand_lat_dp_starts", ds_cnt[0] - ds0, 16);
    chk("rand_lat_queue_empty", q.size(), 0);

    // ABORT while waiting on position 5.
    stray_en = 1'b0; max_lat = 3; hold_blk = 5;
    push_scan(0, -8, 7, -8, 7, 4, 6);
    d0 = done_cnt[0];
    start_scan(0, 1'b0);
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(posedge CLK);
      #1;
      if (DP_START[0] && BLK[0] == 8'd5) found = 1;
    end
    chk("abort_reached_blk5", found, 1);
    @(posedge CLK);
    #1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    chk("abort_busy_low", int'(BUSY[0]), 0);
    chk("abort_no_done", int'(DONE[0]), 0);
    repeat (10) @(posedge CLK);
    #2;
    chk("abort_no_done_later", done_cnt[0] - d0, 0);
    chk("abort_queue_empty", q.size(), 0);
    hold_blk = -1;

    // Restart with START and ABORT high together in IDLE.
    push_scan(0, -8, 7, -8, 7, 4, -1);
    ds0 = ds_cnt[0]; d0 = done_cnt[0];
    start_scan(0, 1'b1);
    wait_done(0, d0, "restart_done");
    chk("restart_dp_starts", ds_cnt[0] - ds0, 16);

    // Reset mid-scan for two cycles.
    push_scan(0, -8, 7, -8, 7, 4, -1);
    start_scan(0, 1'b0);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("midscan_reset_outputs", outs(0), 0);
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    ds0 = ds_cnt[0];
    repeat (30) @(posedge CLK);
    #2;
    chk("reset_no_launch_after", ds_cnt[0] - ds0, 0);
    chk("reset_stays_idle", int'(BUSY[0]), 0);

    // Grid near +127: X=120,124 only, single row at -128.
    max_lat = 5;
    push_scan(1, 120, 127, -128, -128, 4, -1);
    ds0 = ds_cnt[1]; d0 = done_cnt[1];
    start_scan(1, 1'b0);
    wait_done(1, d0, "edge_grid_done");
    chk("edge_grid_dp_starts", ds_cnt[1] - ds0, 2);

    // STEP=64 on a grid holding a single position.
    push_scan(2, 0, 10, 0, 10, 64, -1);
    ds0 = ds_cnt[2]; d0 = done_cnt[2];
    start_scan(2, 1'b0);
    wait_done(2, d0, "single_pos_done");
    chk("single_pos_dp_starts", ds_cnt[2] - ds0, 1);
    chk("final_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
